// File: rtl/clock_time_keeper.sv
// HH:MM:SS BCD time keeper with RUN/SET_H/SET_M/SET_S edit FSM for a 6-digit display.
// time_bcd has zero added latency; disp_mask/point_n lag by one clock; key pulses are never stalled.
module clock_time_keeper #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_mode,
    input  logic        key_inc,
    output logic [23:0] time_bcd,
    output logic [5:0]  disp_mask,
    output logic [5:0]  point_n,
    output logic        sec_tick
);
    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PRE_MAX  = PW'(CLK_FREQ - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(CLK_FREQ / 2);
    localparam logic [BW-1:0] BLK_MAX  = BW'(BLINK_HALF - 1);
    localparam logic [5:0]    PTS_ON   = 6'b101011;

    typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [BW-1:0] blink_cnt;
    logic          blink_ph;
    logic [3:0]    h1, h0, m1, m0, s1, s0;

    logic [3:0] s0_inc, s1_inc, m0_inc, m1_inc, h0_inc, h1_inc;
    logic       s_carry, m_carry, h_wrap;
    logic [5:0] mask_next, pts_next;

    assign time_bcd = {h1, h0, m1, m0, s1, s0};

    // Each field increments with its own wrap; carries are only applied in RUN.
    assign s0_inc  = (s0 == 4'd9) ? 4'd0 : s0 + 4'd1;
    assign s1_inc  = (s0 != 4'd9) ? s1 : ((s1 == 4'd5) ? 4'd0 : s1 + 4'd1);
    assign s_carry = (s0 == 4'd9) && (s1 == 4'd5);
    assign m0_inc  = (m0 == 4'd9) ? 4'd0 : m0 + 4'd1;
    assign m1_inc  = (m0 != 4'd9) ? m1 : ((m1 == 4'd5) ? 4'd0 : m1 + 4'd1);
    assign m_carry = (m0 == 4'd9) && (m1 == 4'd5);
    assign h_wrap  = (h1 == 4'd2) && (h0 == 4'd3);
    assign h0_inc  = (h_wrap || h0 == 4'd9) ? 4'd0 : h0 + 4'd1;
    assign h1_inc  = h_wrap ? 4'd0 : ((h0 == 4'd9) ? h1 + 4'd1 : h1);

    always_comb begin
        mask_next = 6'b111111;
        if (blink_ph) begin
            case (state)
                SET_H:   mask_next = 6'b001111;
                SET_M:   mask_next = 6'b110011;
                SET_S:   mask_next = 6'b111100;
                default: mask_next = 6'b111111;
            endcase
        end
    end

    assign pts_next = (state == RUN && presc >= PRE_HALF) ? 6'b111111 : PTS_ON;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            presc     <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
            {h1, h0, m1, m0, s1, s0} <= 24'h000000;
            disp_mask <= 6'b111111;
            point_n   <= PTS_ON;
            sec_tick  <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            case (state)
                RUN: begin
                    if (presc == PRE_MAX) begin
                        presc    <= '0;
                        sec_tick <= 1'b1;
                        s0       <= s0_inc;
                        s1       <= s1_inc;
                        if (s_carry) begin
                            m0 <= m0_inc;
                            m1 <= m1_inc;
                            if (m_carry) begin
                                h0 <= h0_inc;
                                h1 <= h1_inc;
                            end
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                    // Entering set mode restarts the second from zero.
                    if (key_mode) begin
                        state <= SET_H;
                        presc <= '0;
                    end
                end
                SET_H: begin
                    presc <= '0;
                    if (key_mode) state <= SET_M;
                    else if (key_inc) begin
                        h0 <= h0_inc;
                        h1 <= h1_inc;
                    end
                end
                SET_M: begin
                    presc <= '0;
                    if (key_mode) state <= SET_S;
                    else if (key_inc) begin
                        m0 <= m0_inc;
                        m1 <= m1_inc;
                    end
                end
                SET_S: begin
                    presc <= '0;
                    if (key_mode) state <= RUN;
                    else if (key_inc) begin
                        s0 <= s0_inc;
                        s1 <= s1_inc;
                    end
                end
                default: state <= RUN;
            endcase

            // Any key activity restarts the blink so the edited field shows at once.
            if (state == RUN || key_mode || key_inc) begin
                blink_cnt <= '0;
                blink_ph  <= 1'b0;
            end else if (blink_cnt == BLK_MAX) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end

            disp_mask <= mask_next;
            point_n   <= pts_next;
        end
    end
endmodule

// File: tb/tb_clock_time_keeper.sv
// Directed bench for clock_time_keeper with CLK_FREQ=10, BLINK_HALF=4.
module tb_clock_time_keeper;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        key_mode;
    logic        key_inc;
    logic [23:0] time_bcd;
    logic [5:0]  disp_mask;
    logic [5:0]  point_n;
    logic        sec_tick;

    int checks   = 0;
    int failures = 0;

    clock_time_keeper #(.CLK_FREQ(10), .BLINK_HALF(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .time_bcd  (time_bcd),
        .disp_mask (disp_mask),
        .point_n   (point_n),
        .sec_tick  (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic mode, input logic inc);
        key_mode = mode;
        key_inc  = inc;
        tick();
        key_mode = 1'b0;
        key_inc  = 1'b0;
        tick();
    endtask

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int ticks;
        int hr;
        logic [7:0] hexp;

        rst_n = 1'b0;
        key_mode = 1'b0;
        key_inc = 1'b0;
        tick();
        tick();
        chk("rst_time", time_bcd, 24'h000000);
        chk("rst_mask", {18'h0, disp_mask}, {18'h0, 6'b111111});
        chk("rst_point", {18'h0, point_n}, {18'h0, 6'b101011});
        chk("rst_tick", {23'h0, sec_tick}, 24'h0);

        // First second after reset: prescaler 0..9, point_n seen one clock later.
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk("run_point", {18'h0, point_n}, {18'h0, (k <= 5) ? 6'b101011 : 6'b111111});
            chk("run_tick", {23'h0, sec_tick}, {23'h0, (k == 10)});
            chk("run_time", time_bcd, (k == 10) ? 24'h000001 : 24'h000000);
        end

        // Program 23:59:58.
        press(1'b1, 1'b0);
        for (int i = 0; i < 23; i++) press(1'b0, 1'b1);
        chk("set_hours23", time_bcd, 24'h230001);
        press(1'b1, 1'b0);
        for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
        chk("set_min59", time_bcd, 24'h235901);
        press(1'b1, 1'b0);
        for (int i = 0; i < 57; i++) press(1'b0, 1'b1);
        chk("set_sec58", time_bcd, 24'h235958);

        // Back to RUN; the press already consumed one clock of the new second.
        press(1'b1, 1'b0);
        ticks = 0;
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (sec_tick) ticks++;
            if (i == 8) chk("roll_hold", time_bcd, 24'h235958);
            if (i == 9) chk("roll_235959", time_bcd, 24'h235959);
            if (i == 19) chk("roll_000000", time_bcd, 24'h000000);
        end
        chk("roll_ticks", 24'(ticks), 24'd2);

        // Hours to 07, then minute wrap in SET_M without carry.
        press(1'b1, 1'b0);
        for (int i = 0; i < 7; i++) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        for (int i = 0; i < 59; i++) press(1'b0, 1'b1);
        chk("setm_59", time_bcd, 24'h075900);
        key_inc = 1'b1;
        tick();
        key_inc = 1'b0;
        chk("setm_wrap", time_bcd, 24'h070000);
        chk("setm_point", {18'h0, point_n}, {18'h0, 6'b101011});
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("setm_blink", {18'h0, disp_mask},
                {18'h0, (k >= 5 && k <= 8) ? 6'b110011 : 6'b111111});
        end

        // SET_M -> SET_S -> RUN -> SET_H, hours 07 -> 05.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("seth_entry", time_bcd, 24'h070000);
        for (int i = 0; i < 22; i++) press(1'b0, 1'b1);
        chk("seth_05", time_bcd, 24'h050000);
        press(1'b1, 1'b1);
        chk("both_keys", time_bcd, 24'h050000);
        press(1'b0, 1'b1);
        chk("now_setm", time_bcd, 24'h050100);

        // Reset mid-blink in SET_H.
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("seth_blank", {18'h0, disp_mask}, {18'h0, 6'b001111});
        rst_n = 1'b0;
        #1;
        chk("arst_time", time_bcd, 24'h000000);
        chk("arst_mask", {18'h0, disp_mask}, {18'h0, 6'b111111});
        chk("arst_point", {18'h0, point_n}, {18'h0, 6'b101011});
        tick();
        rst_n = 1'b1;
        press(1'b0, 1'b1);
        chk("arst_inc_ignored", time_bcd, 24'h000000);
        for (int k = 0; k < 8; k++) tick();
        chk("arst_run", time_bcd, 24'h000001);

        // 24 hour increments from 00 in SET_H.
        press(1'b1, 1'b0);
        for (int n = 1; n <= 24; n++) begin
            press(1'b0, 1'b1);
            hr = n % 24;
            hexp = {4'(hr / 10), 4'(hr % 10)};
            chk("hour_step", {16'h0, time_bcd[23:16]}, {16'h0, hexp});
            chk("hour_bcd", {23'h0, (time_bcd[19:16] <= 4'd9 && time_bcd[23:20] <= 4'd2)}, 24'h1);
        end
        chk("hour_final", time_bcd, 24'h000001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
